// File: rtl/buzzer_alarm_sched.sv
// Buzzer scheduler: shares one buzzer among the too-dark, too-bright and
// capture-done alarms. Fixed priority dark > bright > capture; a granted
// beep period (ON phase then OFF phase) always runs to completion before
// the next arbitration.
module buzzer_alarm_sched #(
    parameter int TICK_DIV   = 50000,
    parameter int DARK_ON    = 100,
    parameter int DARK_OFF   = 100,
    parameter int BRIGHT_ON  = 300,
    parameter int BRIGHT_OFF = 300,
    parameter int CAP_ON     = 50,
    parameter int CAP_GAP    = 50
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iReqDark,
    input  logic       iReqBright,
    input  logic       iCapturePulse,
    input  logic       iMute,
    output logic       oSound_on,
    output logic [1:0] oActiveSrc,
    output logic       oBusy
);

    localparam int TW = $clog2(TICK_DIV);

    localparam int MAX_A  = (DARK_ON   > DARK_OFF)   ? DARK_ON   : DARK_OFF;
    localparam int MAX_B  = (BRIGHT_ON > BRIGHT_OFF) ? BRIGHT_ON : BRIGHT_OFF;
    localparam int MAX_C  = (CAP_ON    > CAP_GAP)    ? CAP_ON    : CAP_GAP;
    localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PH_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_DARK   = 2'd1;
    localparam logic [1:0] SRC_BRIGHT = 2'd2;
    localparam logic [1:0] SRC_CAP    = 2'd3;

    logic [TW-1:0]   tickCnt;
    logic            tick;
    logic [1:0]      state;
    logic [1:0]      stateNxt;
    logic [1:0]      srcNxt;
    logic [PH_W-1:0] phaseCnt;
    logic [PH_W-1:0] phaseNxt;
    logic            capPend;
    logic            capGrant;
    logic [1:0]      grantSrc;

    // Phase counter value loaded when a source enters its ON phase.
    function automatic logic [PH_W-1:0] onLoad(input logic [1:0] s);
        case (s)
            SRC_DARK:   onLoad = PH_W'(DARK_ON - 1);
            SRC_BRIGHT: onLoad = PH_W'(BRIGHT_ON - 1);
            default:    onLoad = PH_W'(CAP_ON - 1);
        endcase
    endfunction

    // Phase counter value loaded when a source enters its OFF phase.
    function automatic logic [PH_W-1:0] offLoad(input logic [1:0] s);
        case (s)
            SRC_DARK:   offLoad = PH_W'(DARK_OFF - 1);
            SRC_BRIGHT: offLoad = PH_W'(BRIGHT_OFF - 1);
            default:    offLoad = PH_W'(CAP_GAP - 1);
        endcase
    endfunction

    assign tick = (tickCnt == TW'(TICK_DIV - 1));

    // Free-running tick prescaler; never realigned by grants.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            tickCnt <= '0;
        else if (tick)
            tickCnt <= '0;
        else
            tickCnt <= tickCnt + 1'b1;
    end

    // Fixed-priority arbitration among the live requests.
    always_comb begin
        grantSrc = SRC_NONE;
        if (iReqDark)
            grantSrc = SRC_DARK;
        else if (iReqBright)
            grantSrc = SRC_BRIGHT;
        else if (capPend)
            grantSrc = SRC_CAP;
    end

    // Next-state logic; arbitration only happens in IDLE or at the end of OFF.
    always_comb begin
        stateNxt = state;
        srcNxt   = oActiveSrc;
        phaseNxt = phaseCnt;
        capGrant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grantSrc != SRC_NONE) begin
                    stateNxt = ST_ON;
                    srcNxt   = grantSrc;
                    phaseNxt = onLoad(grantSrc);
                    capGrant = (grantSrc == SRC_CAP);
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (phaseCnt == '0) begin
                        stateNxt = ST_OFF;
                        phaseNxt = offLoad(oActiveSrc);
                    end else begin
                        phaseNxt = phaseCnt - 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (phaseCnt == '0) begin
                        if (grantSrc != SRC_NONE) begin
                            stateNxt = ST_ON;
                            srcNxt   = grantSrc;
                            phaseNxt = onLoad(grantSrc);
                            capGrant = (grantSrc == SRC_CAP);
                        end else begin
                            stateNxt = ST_IDLE;
                            srcNxt   = SRC_NONE;
                        end
                    end else begin
                        phaseNxt = phaseCnt - 1'b1;
                    end
                end
            end
            default: begin
                stateNxt = ST_IDLE;
                srcNxt   = SRC_NONE;
            end
        endcase
    end

    // State, phase counter and outputs all update together so they stay aligned.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= ST_IDLE;
            phaseCnt   <= '0;
            oActiveSrc <= SRC_NONE;
            oSound_on  <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            state      <= stateNxt;
            phaseCnt   <= phaseNxt;
            oActiveSrc <= srcNxt;
            oSound_on  <= (stateNxt == ST_ON) & ~iMute;
            oBusy      <= (stateNxt != ST_IDLE);
        end
    end

    // Pending capture request; a new pulse wins over a same-cycle grant.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            capPend <= 1'b0;
        else if (iCapturePulse)
            capPend <= 1'b1;
        else if (capGrant)
            capPend <= 1'b0;
    end

endmodule

// File: tb/tb_buzzer_alarm_sched.sv
// Directed bench for buzzer_alarm_sched with a short tick (TICK_DIV=4).
// Edge counter e counts rising edges since reset release, so ticks act on
// edges where e is a multiple of 4.
module tb_buzzer_alarm_sched;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iReqDark = 1'b0;
    logic       iReqBright = 1'b0;
    logic       iCapturePulse = 1'b0;
    logic       iMute = 1'b0;
    logic       oSound_on;
    logic [1:0] oActiveSrc;
    logic       oBusy;

    int nCmp = 0;
    int nErr = 0;
    int e = 0;

    buzzer_alarm_sched #(
        .TICK_DIV(4), .DARK_ON(2), .DARK_OFF(2), .BRIGHT_ON(3),
        .BRIGHT_OFF(3), .CAP_ON(1), .CAP_GAP(2)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iReqDark(iReqDark), .iReqBright(iReqBright),
        .iCapturePulse(iCapturePulse), .iMute(iMute), .oSound_on(oSound_on),
        .oActiveSrc(oActiveSrc), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input int got, input int exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s @e=%0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    // Check all three outputs at once.
    task automatic checkOut(input string tag, input int snd, input int src, input int busy);
        checkVal({tag, ".sound"}, int'(oSound_on), snd);
        checkVal({tag, ".src"}, int'(oActiveSrc), src);
        checkVal({tag, ".busy"}, int'(oBusy), busy);
    endtask

    // Advance to the falling edge after rising edge n.
    task automatic goto(input int n);
        while (e < n) begin
            @(posedge iCLK);
            e++;
            @(negedge iCLK);
        end
    endtask

    task automatic doReset();
        @(negedge iCLK);
        iRST = 1'b0;
        iReqDark = 1'b0;
        iReqBright = 1'b0;
        iCapturePulse = 1'b0;
        iMute = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        e = 0;
    endtask

    task automatic pulseCap(input int at);
        goto(at);
        iCapturePulse = 1'b1;
        goto(at + 1);
        iCapturePulse = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge iCLK);
        checkOut("rst", 0, 0, 0);

        // 1. Dark held: ON edges 1..8, OFF 8..16, ON again at 16, 24, 32 ...
        doReset();
        iReqDark = 1'b1;
        goto(1);  checkOut("dark.on1", 1, 1, 1);
        goto(7);  checkOut("dark.on1end", 1, 1, 1);
        goto(8);  checkOut("dark.off1", 0, 1, 1);
        goto(15); checkOut("dark.off1end", 0, 1, 1);
        goto(16); checkOut("dark.on2", 1, 1, 1);
        goto(23); checkOut("dark.on2end", 1, 1, 1);
        goto(24); checkOut("dark.off2", 0, 1, 1);
        goto(32); checkOut("dark.on3", 1, 1, 1);

        // 2. Bright period completes despite dark arriving mid-ON
        doReset();
        iReqBright = 1'b1;
        goto(1);  checkOut("bri.on", 1, 2, 1);
        goto(5);  iReqDark = 1'b1;
        goto(11); checkOut("bri.onend", 1, 2, 1);
        goto(12); checkOut("bri.off", 0, 2, 1);
        goto(23); checkOut("bri.offend", 0, 2, 1);
        goto(24); checkOut("bri.todark", 1, 1, 1);

        // 3. Single capture while idle: latched at edge 1, granted at edge 2
        doReset();
        pulseCap(0);
        checkOut("cap.latch", 0, 0, 0);
        goto(2);  checkOut("cap.on", 1, 3, 1);
        goto(3);  checkOut("cap.on2", 1, 3, 1);
        goto(4);  checkOut("cap.gap", 0, 3, 1);
        goto(11); checkOut("cap.gapend", 0, 3, 1);
        goto(12); checkOut("cap.idle", 0, 0, 0);
        goto(20); checkOut("cap.noregrant", 0, 0, 0);

        // 4. Three captures during dark, dark drops in OFF: one chirp at edge 16
        doReset();
        iReqDark = 1'b1;
        pulseCap(2);
        pulseCap(4);
        pulseCap(6);
        goto(8);  checkOut("mix.darkoff", 0, 1, 1);
        goto(10); iReqDark = 1'b0;
        goto(15); checkOut("mix.offend", 0, 1, 1);
        goto(16); checkOut("mix.chirp", 1, 3, 1);
        goto(20); checkOut("mix.gap", 0, 3, 1);
        goto(28); checkOut("mix.idle", 0, 0, 0);
        goto(40); checkOut("mix.onechirp", 0, 0, 0);

        // 5. Mute during dark ON silences one cycle later, schedule continues
        doReset();
        iReqDark = 1'b1;
        goto(3);  checkOut("mute.pre", 1, 1, 1);
        iMute = 1'b1;
        goto(4);  checkOut("mute.on", 0, 1, 1);
        goto(10); iMute = 1'b0;
        goto(12); checkOut("mute.off", 0, 1, 1);
        goto(16); checkOut("mute.resume", 1, 1, 1);

        // 6. Async reset mid-ON drops outputs at once and loses cap_pend
        doReset();
        iReqDark = 1'b1;
        pulseCap(2);
        checkOut("rst.pre", 1, 1, 1);
        iRST = 1'b0;
        #1;
        checkOut("rst.async", 0, 0, 0);
        iReqDark = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        e = 0;
        goto(20); checkOut("rst.idle", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
